morse_timing_decoder: RTL and testbench
=======================================

MORSE_TIMING_DECODER -- requirements
Module: morse_timing_decoder

Interface
REQ-001 The block SHALL have parameter MAX_SYMBOLS, default 4: the maximum number of symbols per letter (range 1..8).
REQ-002 The block SHALL have parameter TICK_DIV, default 1000: clock cycles per timing tick (at least 2).
REQ-003 The block SHALL have parameter DASH_TICKS, default 3: the minimum press duration, in ticks, classified as a dash.
REQ-004 The block SHALL have parameter GAP_TICKS, default 5: the release duration, in ticks, that ends a letter.
REQ-005 The block SHALL have parameter CNT_W, default 8: the width of the duration and gap counters, which saturate at 2^CNT_W-1.
REQ-006 Port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 Port key_in, input, 1 bit: the already-debounced player key, level-sensitive, high while pressed.
REQ-009 Port out_code, output, 2*MAX_SYMBOLS bits: the packed letter; symbol i occupies bits [2i+1:2i], and symbol 0 is the first keyed; 2'b01 = dot, 2'b10 = dash, 2'b00 = empty.
REQ-010 Port out_len, output, clog2(MAX_SYMBOLS+1) bits: the number of valid symbols in out_code.
REQ-011 Port out_valid, output, 1 bit: out_code and out_len hold a committed letter.
REQ-012 Port out_ready, input, 1 bit: the consumer accepts the letter when out_ready and out_valid are both high.
REQ-013 Port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 Port dropped, output, 1 bit: a one-cycle pulse when a key press is discarded.

Function
REQ-015 The block SHALL register key_in into key_q and define rise = key_in & ~key_q and fall = ~key_in & key_q.
REQ-016 The tick prescaler SHALL count 0..TICK_DIV-1, emit tick when at TICK_DIV-1, and clear to 0 on every accepted rise or fall.
REQ-017 The FSM SHALL have states IDLE, PRESS, GAP and HOLD.
REQ-018 In IDLE, a rise SHALL go to PRESS with dur=0; nothing else has effect.
REQ-019 In PRESS, dur SHALL increment on each tick, saturating; a press of N high cycles gives dur = floor(N/TICK_DIV).
REQ-020 In PRESS, a fall SHALL append a dash if dur >= DASH_TICKS, otherwise a dot, at slot sym_cnt, then increment sym_cnt.
REQ-021 After that append, if sym_cnt reaches MAX_SYMBOLS the block SHALL commit immediately to HOLD; otherwise it SHALL go to GAP with gap=0.
REQ-022 In GAP, gap SHALL increment on each tick; a rise SHALL go to PRESS with dur=0; when gap reaches GAP_TICKS the block SHALL commit to HOLD.
REQ-023 If a rise and the GAP_TICKS-reaching tick occur in the same cycle, the rise SHALL win and the letter SHALL continue.
REQ-024 On commit, the block SHALL register out_code/out_len, and out_valid SHALL be high in the cycle after the commit condition.
REQ-025 In HOLD, out_code, out_len and out_valid SHALL be held stable until a handshake.
REQ-026 On handshake, the block SHALL go to IDLE next cycle with out_valid=0, the code register cleared, and sym_cnt=0.
REQ-027 In HOLD, every rise SHALL pulse dropped for one cycle and SHALL NOT be recorded.
REQ-028 A key still held on return to IDLE SHALL be ignored until its next rise.
REQ-029 A fall in IDLE or HOLD SHALL be ignored.
REQ-030 Unused high symbol slots of out_code SHALL always read 2'b00.
REQ-031 The only outputs driven combinationally from state SHALL be out_valid, busy and dropped; out_code and out_len SHALL be registers.

Reset
REQ-032 While rst is high at a clock edge, the block SHALL set state=IDLE, out_valid=0, out_code=0, out_len=0, busy=0, dropped=0, and clear key_q, prescaler, dur, gap and sym_cnt.
REQ-033 A reset mid-letter SHALL discard all partial symbols, and a reset in HOLD SHALL discard the pending letter without a handshake.
REQ-034 A key held high through reset release SHALL be treated as a new press, since key_q=0 makes it a rise.

Verification (TICK_DIV=4, DASH_TICKS=3, GAP_TICKS=5, MAX_SYMBOLS=4, out_ready=1 unless stated)
REQ-035 Letter "A": key high 4 cycles, low 4 cycles, high 16 cycles, then low -> out_valid one cycle after the 20th low cycle, with out_code=8'b00001001 and out_len=2.
REQ-036 Auto-commit: four presses of 4 cycles, each separated by 4 low cycles -> out_valid the cycle after the 4th fall, with out_code=8'b01010101, out_len=4, and no gap wait.
REQ-037 Backpressure: out_ready=0 for 40 cycles while two key pulses arrive in HOLD -> out_code stable, dropped pulses twice, and the accepted letter is unchanged.
REQ-038 Classification boundary: a press of 11 cycles (dur=2) gives a dot and a press of 12 cycles (dur=3) gives a dash.
REQ-039 Rise coincident with the gap timeout tick -> no commit, PRESS entered, and out_len later counts the extra symbol.
REQ-040 Reset after two symbols -> all outputs 0 next cycle; the next keyed "E" (one dot) yields out_code=8'b00000001 and out_len=1.

Source files
------------

// File: rtl/morse_timing_decoder.sv
// -----------------------------------------------------------------------------
// morse_timing_decoder
//
// Turns a debounced Morse key into packed letters. Press length (in prescaled
// ticks) selects dot or dash; a long enough release, or filling every symbol
// slot, commits the letter, which is then held until the consumer takes it.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   key_in     in   debounced key level, high while pressed
//   out_code   out  packed letter, symbol i at [2i+1:2i], symbol 0 keyed first
//                   (01 = dot, 10 = dash, 00 = empty slot)
//   out_len    out  number of valid symbols in out_code
//   out_valid  out  out_code/out_len hold a committed letter
//   out_ready  in   consumer accepts the letter when out_valid is also high
//   busy       out  high whenever the decoder is not idle
//   dropped    out  one-cycle pulse when a press arrives while a letter waits
// -----------------------------------------------------------------------------
module morse_timing_decoder #(
  parameter int MAX_SYMBOLS = 4,
  parameter int TICK_DIV    = 1000,
  parameter int DASH_TICKS  = 3,
  parameter int GAP_TICKS   = 5,
  parameter int CNT_W       = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               key_in,
  output logic [2*MAX_SYMBOLS-1:0]           out_code,
  output logic [$clog2(MAX_SYMBOLS+1)-1:0]   out_len,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               busy,
  output logic                               dropped
);

  localparam int LEN_W  = $clog2(MAX_SYMBOLS + 1);
  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int CODE_W = 2 * MAX_SYMBOLS;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;

  logic [1:0]        state_q,    state_d;
  logic              key_q;
  logic [PRE_W-1:0]  presc_q,    presc_d;
  logic [CNT_W-1:0]  dur_q,      dur_d;
  logic [CNT_W-1:0]  gap_q,      gap_d;
  logic [LEN_W-1:0]  sym_cnt_q,  sym_cnt_d;
  logic [CODE_W-1:0] code_q,     code_d;
  logic [CODE_W-1:0] out_code_q, out_code_d;
  logic [LEN_W-1:0]  out_len_q,  out_len_d;

  logic              rise, fall, tick;
  logic [CNT_W-1:0]  dur_inc, gap_inc;
  logic [1:0]        sym;
  logic [CODE_W-1:0] code_app;
  logic              last_slot;

  assign rise = key_in & ~key_q;
  assign fall = ~key_in & key_q;
  assign tick = (presc_q == PRE_W'(TICK_DIV - 1));

  // Counters saturate. The falling-edge cycle's own tick is folded into the
  // classification so N high cycles give exactly floor(N/TICK_DIV) ticks.
  assign dur_inc = (tick && (dur_q != '1)) ? dur_q + 1'b1 : dur_q;
  assign gap_inc = (tick && (gap_q != '1)) ? gap_q + 1'b1 : gap_q;

  assign sym       = (dur_inc >= CNT_W'(DASH_TICKS)) ? SYM_DASH : SYM_DOT;
  assign last_slot = (sym_cnt_q == LEN_W'(MAX_SYMBOLS - 1));

  // Working code with the current symbol written into slot sym_cnt_q; slots
  // above it stay zero, so unused high slots always read empty.
  always_comb begin
    code_app = code_q;
    for (int i = 0; i < MAX_SYMBOLS; i++) begin
      if (sym_cnt_q == LEN_W'(i)) code_app[2*i +: 2] = sym;
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path through
    // the case leaves one unassigned, which would infer a latch.
    state_d    = state_q;
    presc_d    = tick ? '0 : presc_q + 1'b1;
    dur_d      = dur_q;
    gap_d      = gap_q;
    sym_cnt_d  = sym_cnt_q;
    code_d     = code_q;
    out_code_d = out_code_q;
    out_len_d  = out_len_q;

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d = S_PRESS;
          dur_d   = '0;
          presc_d = '0;
        end
      end

      S_PRESS: begin
        dur_d = dur_inc;
        if (fall) begin
          presc_d   = '0;
          code_d    = code_app;
          sym_cnt_d = sym_cnt_q + 1'b1;
          if (last_slot) begin
            // Every slot filled: no point waiting out the gap.
            state_d    = S_HOLD;
            out_code_d = code_app;
            out_len_d  = sym_cnt_q + 1'b1;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
          end
        end
      end

      S_GAP: begin
        // A rise takes priority over a timeout tick in the same cycle.
        if (rise) begin
          state_d = S_PRESS;
          dur_d   = '0;
          presc_d = '0;
        end else begin
          gap_d = gap_inc;
          if (gap_inc >= CNT_W'(GAP_TICKS)) begin
            state_d    = S_HOLD;
            out_code_d = code_q;
            out_len_d  = sym_cnt_q;
          end
        end
      end

      S_HOLD: begin
        if (out_ready) begin
          state_d    = S_IDLE;
          code_d     = '0;
          sym_cnt_d  = '0;
          out_code_d = '0;
          out_len_d  = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= S_IDLE;
      key_q      <= 1'b0;
      presc_q    <= '0;
      dur_q      <= '0;
      gap_q      <= '0;
      sym_cnt_q  <= '0;
      code_q     <= '0;
      out_code_q <= '0;
      out_len_q  <= '0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_in;
      presc_q    <= presc_d;
      dur_q      <= dur_d;
      gap_q      <= gap_d;
      sym_cnt_q  <= sym_cnt_d;
      code_q     <= code_d;
      out_code_q <= out_code_d;
      out_len_q  <= out_len_d;
    end
  end

  assign out_code  = out_code_q;
  assign out_len   = out_len_q;
  assign out_valid = (state_q == S_HOLD);
  assign busy      = (state_q != S_IDLE);
  assign dropped   = (state_q == S_HOLD) & rise;

endmodule

// File: tb/tb_morse_timing_decoder.sv
// -----------------------------------------------------------------------------
// tb_morse_timing_decoder
//
// Scoreboard bench: stimulus pushes expected letters, a negedge monitor pops
// and compares on every handshake. Random letters are predicted from press and
// release lengths alone (ticks = cycles / TICK_DIV).
// -----------------------------------------------------------------------------
module tb_morse_timing_decoder;

  localparam int MS      = 4;
  localparam int TD      = 4;
  localparam int DT      = 3;
  localparam int GT      = 5;
  localparam int CW      = 8;
  localparam int LW      = $clog2(MS + 1);
  localparam int TIMEOUT = GT * TD;  // low cycles after which a letter ends

  logic              clk = 1'b0;
  logic              rst;
  logic              key_in;
  logic              out_ready;
  logic [2*MS-1:0]   out_code;
  logic [LW-1:0]     out_len;
  logic              out_valid;
  logic              busy;
  logic              dropped;

  always #5 clk = ~clk;

  morse_timing_decoder #(
    .MAX_SYMBOLS (MS),
    .TICK_DIV    (TD),
    .DASH_TICKS  (DT),
    .GAP_TICKS   (GT),
    .CNT_W       (CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_in    (key_in),
    .out_code  (out_code),
    .out_len   (out_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .dropped   (dropped)
  );

  int checks   = 0;
  int errors   = 0;
  int drop_cnt = 0;

  logic [2*MS-1:0] exp_code_q[$];
  logic [LW-1:0]   exp_len_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic expect_letter(input logic [2*MS-1:0] code, input int len);
    exp_code_q.push_back(code);
    exp_len_q.push_back(LW'(len));
  endtask

  // One clock cycle with the key at level k; returns just after the edge.
  task automatic step(input logic k);
    key_in = k;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int high, input int low);
    repeat (high) step(1'b1);
    repeat (low) step(1'b0);
  endtask

  // Reference: each press becomes a dash when it spans DT whole ticks; a
  // letter ends when all MS slots fill or the following release outlasts
  // TIMEOUT cycles.
  task automatic model_stream(input int p[$], input int g[$]);
    logic [2*MS-1:0] code;
    int cnt;
    code = '0;
    cnt  = 0;
    foreach (p[i]) begin
      code[2*cnt +: 2] = ((p[i] / TD) >= DT) ? 2'b10 : 2'b01;
      cnt++;
      if (cnt == MS || g[i] > TIMEOUT) begin
        expect_letter(code, cnt);
        code = '0;
        cnt  = 0;
      end
    end
  endtask

  // Monitor: counts dropped pulses and scores every accepted letter.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (dropped) drop_cnt++;
        if (out_valid && out_ready) begin
          if (exp_code_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_letter actual=%0h/%0d expected=none", out_code, out_len);
          end else begin
            check("letter_code", out_code, exp_code_q.pop_front());
            check("letter_len", out_len, exp_len_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int p[$];
    int g[$];

    rst       = 1'b1;
    key_in    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_code", out_code, 0);
    check("rst_len", out_len, 0);
    check("rst_busy", busy, 0);
    check("rst_dropped", dropped, 0);
    rst = 1'b0;
    repeat (3) step(1'b0);

    // Letter A: dot then dash, committed by the gap timeout.
    expect_letter(8'b0000_1001, 2);
    press(4, 4);
    repeat (16) step(1'b1);
    check("a_busy", busy, 1);
    n = 0;
    do begin
      step(1'b0);
      n++;
    end while (!out_valid && n < 40);
    check("a_commit_latency", n, TIMEOUT + 1);
    repeat (5) step(1'b0);

    // Four dots fill every slot and commit on the last fall.
    expect_letter(8'b0101_0101, 4);
    repeat (3) press(4, 4);
    repeat (4) step(1'b1);
    step(1'b0);
    check("auto_valid", out_valid, 1);
    check("auto_len", out_len, 4);
    repeat (5) step(1'b0);

    // Backpressure: two presses arrive while the letter waits.
    out_ready = 1'b0;
    expect_letter(8'b0000_0110, 2);
    press(12, 4);
    repeat (4) step(1'b1);
    n = 0;
    do begin
      step(1'b0);
      n++;
    end while (!out_valid && n < 40);
    check("bp_commit", out_valid, 1);
    drop_cnt = 0;
    bad      = 0;
    for (int i = 0; i < 40; i++) begin
      step((i < 3) || (i >= 8 && i < 11));
      if (out_code !== 8'b0000_0110 || out_len !== LW'(2) || !out_valid || !busy) bad++;
    end
    check("bp_stable", bad, 0);
    check("bp_dropped", drop_cnt, 2);
    out_ready = 1'b1;
    step(1'b0);
    check("bp_release_valid", out_valid, 0);
    check("bp_release_code", out_code, 0);
    repeat (3) step(1'b0);

    // Classification boundary: 11 cycles is a dot, 12 a dash.
    expect_letter(8'b0000_1001, 2);
    press(11, 5);
    press(12, 30);
    expect_letter(8'b0000_0110, 2);
    press(12, 5);
    press(11, 30);

    // Rise lands on the gap timeout tick: letter continues.
    expect_letter(8'b0000_0101, 2);
    press(4, 0);
    bad = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      step(1'b0);
      if (out_valid) bad++;
    end
    check("coinc_no_commit", bad, 0);
    press(4, 30);

    // Reset after two symbols discards them.
    press(4, 4);
    press(12, 3);
    rst = 1'b1;
    step(1'b0);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_code", out_code, 0);
    check("mid_rst_len", out_len, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dropped", dropped, 0);
    rst = 1'b0;
    expect_letter(8'b0000_0001, 1);
    press(4, 30);

    // Key held through reset release is a fresh press.
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    expect_letter(8'b0000_0010, 1);
    press(12, 30);

    // Random letters; release lengths avoid the window where a press would
    // land in the one-cycle hold after a timeout commit.
    drop_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      p.push_back($urandom_range(1, 16));
      if (i == 29 || $urandom_range(0, 2) == 0) g.push_back($urandom_range(TIMEOUT + 4, TIMEOUT + 12));
      else g.push_back($urandom_range(2, TIMEOUT));
    end
    model_stream(p, g);
    foreach (p[i]) press(p[i], g[i]);
    repeat (5) step(1'b0);
    check("rand_no_drops", drop_cnt, 0);

    n = 0;
    while (exp_code_q.size() > 0 && n < 100) begin
      step(1'b0);
      n++;
    end
    check("scoreboard_drained", exp_code_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
